panel_scan_driver: RTL and testbench
====================================

Name: panel_scan_driver

Overview:
Read-side consumer of the dual-bank pixel RAM. It scans the RAM row by row and drives a HUB75 64x64 1/32-scan LED panel using binary-coded modulation (BCM).
- Addresses RAM words {row, col}; gets top-half (bank1) and bottom-half (bank2) pixels in parallel.
- Serialises one bit plane per pass, then latches the plane and gates OE for a plane-weighted time.

Parameters:
COLS, 64, columns per row; power of two; col counter width = log2(COLS)
ROW_W, 5, scan-row address width (32 rows per bank)
PLANES, 5, bit planes per colour channel (MSBs of each RGB565 field)
BASE_OE, 8, OE-active i_clk cycles for plane 0 (LSB); plane p lasts BASE_OE<<p

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  run scanning; low = stop at next plane boundary
o_r_addr  out  ROW_W+log2(COLS) (11)  RAM read address {row, col}
o_r_enable  out  1  RAM read enable; data valid one cycle later
i_bank1_data  in  16  RGB565 pixel, top half
i_bank2_data  in  16  RGB565 pixel, bottom half
o_rgb1  out  3  {R1,G1,B1} panel data
o_rgb2  out  3  {R2,G2,B2} panel data
o_panel_clk  out  1  panel shift clock
o_lat  out  1  panel latch
o_oe_n  out  1  panel output enable, active low
o_row  out  ROW_W  panel row address A..E
o_frame_done  out  1  one-cycle pulse after the last plane of the last row

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0 except o_oe_n=1; state IDLE; row=0, plane=0, col=0. Takes effect mid-operation with no completion of the current pass.
- Bit extraction for plane p (0..PLANES-1):
  - R = d[11+p]
  - G = d[6+p] (top 5 bits of G6)
  - B = d[0+p]
  - Order is {R,G,B}.
- IDLE: o_oe_n=1. Go to SHIFT when i_enable=1. Row and plane keep their values.
- SHIFT takes 2 cycles per column, c = 0..COLS-1:
  - Phase 0: o_r_enable=1, o_r_addr={row,c}. o_panel_clk=1 for c>0 (clocks in column c-1); o_panel_clk=0 for c=0.
  - Phase 1: o_r_enable=0. o_rgb1/o_rgb2 load the extracted plane bits from the RAM data. o_panel_clk=0.
  - o_oe_n stays as left by the previous DISPLAY (1).
- TAIL, 1 cycle: o_panel_clk=1 clocks in the last column.
- BLANK, 1 cycle: o_panel_clk=0, o_oe_n=1, o_row<=row.
- LATCH, 1 cycle: o_lat=1.
- DISPLAY: o_lat=0 and o_oe_n=0 for exactly BASE_OE<<plane cycles. On the final cycle, plane advances:
  - If plane==PLANES-1: plane->0 and row advances.
  - If row==2^ROW_W-1: row->0 and o_frame_done pulses on the first cycle after DISPLAY.
- After DISPLAY: o_oe_n=1. Go to SHIFT if i_enable=1, else IDLE. i_enable is sampled only here and in IDLE.
- Cycles per plane = 2*COLS + 3 + (BASE_OE<<plane); with defaults, 131 + 8<<p.
- o_rgb holds its last value outside SHIFT.
- Counters wrap modulo their widths; no other arithmetic.

Decomposition:
- Package panel_pkg holds:
  - RGB565 field offsets (R_LSB=11, G_LSB=6, B_LSB=0)
  - state encoding: IDLE, SHIFT, TAIL, BLANK, LATCH, DISPLAY
  - plane-bit extraction function
- One sub-module, panel_oe_timer: loadable down-counter, loaded with BASE_OE<<plane on entering DISPLAY. Outputs o_busy and a one-cycle o_done; counter width = log2(BASE_OE)+PLANES.

Test Plan:
- Reset -> o_oe_n=1, all other outputs 0. Assert i_rst_n=0 mid-SHIFT at col 17 -> same values on the same cycle, and after release the scan restarts at row 0, plane 0, col 0.
- RAM model with bank1[a]=a, bank2=16'hF800; enable -> o_r_addr steps 0..63 once every 2 cycles in row 0. o_rgb2=3'b100 for every plane. o_rgb1 matches the extracted bits of the address value. 64 o_panel_clk rising edges per pass.
- Per-plane timing -> o_oe_n low for 8, 16, 32, 64, 128 cycles on planes 0..4. o_lat high exactly 1 cycle, one cycle after o_row updates, with o_oe_n=1 at that time.
- Full frame -> o_frame_done pulses once after 32 rows × 5 planes. Frame length is 32*(5*131+248)=28896 cycles. o_row then wraps 31->0.
- Drop i_enable during SHIFT of row 3 plane 2 -> that plane completes (latch and display), then IDLE with o_oe_n=1. Re-enable -> resumes at row 3 plane 3.
- Pixel 16'hFFFF in bank1[{5'd0,6'd63}] and 0 elsewhere -> only the last shifted bit of row 0 is 3'b111 on o_rgb1, and it is clocked by the TAIL edge.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared definitions for the HUB75 panel scan driver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package panel_pkg;

    // Bit offsets of the colour fields inside an RGB565 word. G starts at
    // bit 6 rather than 5 so that the five plane bits are the top five of G6.
    localparam int R_LSB = 11;
    localparam int G_LSB = 6;
    localparam int B_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        TAIL,
        BLANK,
        LATCH,
        DISPLAY
    } state_e;

    // Pick bit 'plane' out of each colour field, packed as {R,G,B}.
    function automatic logic [2:0] plane_bits(input logic [15:0] pix,
                                              input logic [3:0]  plane);
        logic [3:0] r_idx;
        logic [3:0] g_idx;
        logic [3:0] b_idx;
        r_idx = 4'(R_LSB) + plane;
        g_idx = 4'(G_LSB) + plane;
        b_idx = 4'(B_LSB) + plane;
        return {pix[r_idx], pix[g_idx], pix[b_idx]};
    endfunction

endpackage

// File: rtl/panel_oe_timer.sv
// Loadable down-counter that times the OE-active window of one bit plane.
// Latency: i_load sets the count next cycle; o_done is high on the last of i_len busy cycles.
// Backpressure: none; a load always overrides a running count.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load/i_len start a
//        window of i_len cycles; o_busy high while counting; o_done one-cycle end pulse.
module panel_oe_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_len;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_busy = (cnt_q != '0);
    assign o_done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/panel_scan_driver.sv
// Scans the dual-bank pixel RAM and drives a HUB75 1/32-scan panel with binary-coded modulation.
// Latency: one plane pass = 2*COLS + 3 + (BASE_OE << plane) cycles; RAM data is used one cycle after o_r_enable.
// Backpressure: none; i_enable low stops scanning at the next plane boundary.
// Ports: o_r_addr/o_r_enable read the RAM ({row,col}); i_bank1/2_data are top/bottom pixels;
//        o_rgb1/o_rgb2, o_panel_clk, o_lat, o_oe_n, o_row drive the panel; o_frame_done pulses per frame.
module panel_scan_driver
    import panel_pkg::*;
#(
    parameter int COLS    = 64,
    parameter int ROW_W   = 5,
    parameter int PLANES  = 5,
    parameter int BASE_OE = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_enable,
    output logic [ROW_W+$clog2(COLS)-1:0]  o_r_addr,
    output logic                           o_r_enable,
    input  logic [15:0]                    i_bank1_data,
    input  logic [15:0]                    i_bank2_data,
    output logic [2:0]                     o_rgb1,
    output logic [2:0]                     o_rgb2,
    output logic                           o_panel_clk,
    output logic                           o_lat,
    output logic                           o_oe_n,
    output logic [ROW_W-1:0]               o_row,
    output logic                           o_frame_done
);

    localparam int COL_W   = $clog2(COLS);
    localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int CNT_W   = $clog2(BASE_OE) + PLANES;
    localparam int ADDR_W  = ROW_W + COL_W;

    state_e              state_q;
    logic [ROW_W-1:0]    row_q;
    logic [PLANE_W-1:0]  plane_q;
    logic [COL_W-1:0]    col_q;
    logic                phase_q;

    logic [ADDR_W-1:0]   r_addr_q;
    logic                r_en_q;
    logic [2:0]          rgb1_q;
    logic [2:0]          rgb2_q;
    logic                pclk_q;
    logic                lat_q;
    logic                oe_n_q;
    logic [ROW_W-1:0]    row_out_q;
    logic                frame_done_q;

    logic [COL_W-1:0]    col_nxt;
    logic [ROW_W-1:0]    row_nxt;
    logic [PLANE_W-1:0]  plane_nxt;
    logic                last_plane;
    logic [ROW_W-1:0]    row_adv;
    logic [CNT_W-1:0]    oe_len;
    logic                oe_busy;
    logic                oe_done;

    assign col_nxt    = col_q + COL_W'(1);
    assign row_nxt    = row_q + ROW_W'(1);
    assign plane_nxt  = plane_q + PLANE_W'(1);
    assign last_plane = (plane_q == PLANE_W'(PLANES - 1));
    // Row used by the pass that follows the current DISPLAY.
    assign row_adv    = last_plane ? row_nxt : row_q;
    assign oe_len     = CNT_W'(BASE_OE) << plane_q;

    // Load on the LATCH cycle so the count is live for the first DISPLAY cycle.
    panel_oe_timer #(
        .CNT_W (CNT_W)
    ) u_oe_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (state_q == LATCH),
        .i_len   (oe_len),
        .o_busy  (oe_busy),
        .o_done  (oe_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            r_addr_q     <= '0;
            r_en_q       <= 1'b0;
            rgb1_q       <= '0;
            rgb2_q       <= '0;
            pclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            row_out_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    oe_n_q <= 1'b1;
                    if (i_enable) begin
                        state_q  <= SHIFT;
                        col_q    <= '0;
                        phase_q  <= 1'b0;
                        r_en_q   <= 1'b1;
                        r_addr_q <= {row_q, COL_W'(0)};
                        pclk_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!phase_q) begin
                        // Read issued this cycle; the panel clock falls.
                        phase_q <= 1'b1;
                        r_en_q  <= 1'b0;
                        pclk_q  <= 1'b0;
                    end else begin
                        // RAM data is valid now; present it and raise the
                        // panel clock on the next cycle to shift it in.
                        rgb1_q <= plane_bits(i_bank1_data, 4'(plane_q));
                        rgb2_q <= plane_bits(i_bank2_data, 4'(plane_q));
                        pclk_q <= 1'b1;
                        if (col_q == COL_W'(COLS - 1)) begin
                            state_q <= TAIL;
                        end else begin
                            col_q    <= col_nxt;
                            phase_q  <= 1'b0;
                            r_en_q   <= 1'b1;
                            r_addr_q <= {row_q, col_nxt};
                        end
                    end
                end
                TAIL: begin
                    state_q   <= BLANK;
                    pclk_q    <= 1'b0;
                    oe_n_q    <= 1'b1;
                    row_out_q <= row_q;
                end
                BLANK: begin
                    state_q <= LATCH;
                    lat_q   <= 1'b1;
                end
                LATCH: begin
                    state_q <= DISPLAY;
                    lat_q   <= 1'b0;
                    oe_n_q  <= 1'b0;
                end
                DISPLAY: begin
                    // The !oe_busy term only guards against a stalled timer.
                    if (oe_done || !oe_busy) begin
                        oe_n_q <= 1'b1;
                        if (last_plane) begin
                            plane_q <= '0;
                            row_q   <= row_nxt;
                            if (row_q == '1) begin
                                frame_done_q <= 1'b1;
                            end
                        end else begin
                            plane_q <= plane_nxt;
                        end
                        if (i_enable) begin
                            state_q  <= SHIFT;
                            col_q    <= '0;
                            phase_q  <= 1'b0;
                            r_en_q   <= 1'b1;
                            r_addr_q <= {row_adv, COL_W'(0)};
                            pclk_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_r_addr     = r_addr_q;
    assign o_r_enable   = r_en_q;
    assign o_rgb1       = rgb1_q;
    assign o_rgb2       = rgb2_q;
    assign o_panel_clk  = pclk_q;
    assign o_lat        = lat_q;
    assign o_oe_n       = oe_n_q;
    assign o_row        = row_out_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_panel_scan_driver.sv
// Directed bench for panel_scan_driver with a registered dual-bank RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_panel_scan_driver;

    localparam int COLS    = 64;
    localparam int ROW_W   = 5;
    localparam int PLANES  = 5;
    localparam int BASE_OE = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [10:0] r_addr;
    logic        r_en;
    logic [15:0] b1;
    logic [15:0] b2;
    logic [2:0]  rgb1;
    logic [2:0]  rgb2;
    logic        pclk;
    logic        lat;
    logic        oe_n;
    logic [4:0]  row;
    logic        fdone;

    logic [15:0] mem1 [0:2047];
    logic [15:0] mem2 [0:2047];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fd_cnt  = 0;
    int last_nz = 0;
    logic [2:0] last_tail_rgb;

    always #5 clk = ~clk;

    // RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (r_en) begin
            b1 <= mem1[r_addr];
            b2 <= mem2[r_addr];
        end
    end

    panel_scan_driver #(
        .COLS    (COLS),
        .ROW_W   (ROW_W),
        .PLANES  (PLANES),
        .BASE_OE (BASE_OE)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .o_r_addr     (r_addr),
        .o_r_enable   (r_en),
        .i_bank1_data (b1),
        .i_bank2_data (b2),
        .o_rgb1       (rgb1),
        .o_rgb2       (rgb2),
        .o_panel_clk  (pclk),
        .o_lat        (lat),
        .o_oe_n       (oe_n),
        .o_row        (row),
        .o_frame_done (fdone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plane bit p of each RGB565 field, {R,G,B}.
    function automatic logic [2:0] ex(input logic [15:0] v, input int p);
        logic [15:0] t;
        t = v >> p;
        return {t[11], t[6], t[0]};
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (fdone === 1'b1) fd_cnt++;
    endtask

    // Walk one full plane pass of row r, plane p, starting at the cycle
    // before its first SHIFT cycle.
    task automatic run_pass(input int r, input int p);
        int   rises;
        int   nz;
        logic prev;
        rises = 0;
        nz    = 0;
        prev  = pclk;
        for (int c = 0; c < COLS; c++) begin
            tick();
            chk("shift_ren", 32'(r_en), 1);
            chk("shift_addr", 32'(r_addr), r * 64 + c);
            chk("shift_pclk", 32'(pclk), (c > 0) ? 1 : 0);
            chk("shift_oe_n", 32'(oe_n), 1);
            if (pclk && !prev) rises++;
            if (pclk && rgb1 != 3'b000) nz++;
            if (c > 0) begin
                chk("shift_rgb1", 32'(rgb1), 32'(ex(mem1[r * 64 + c - 1], p)));
                chk("shift_rgb2", 32'(rgb2), 32'(ex(mem2[r * 64 + c - 1], p)));
            end
            prev = pclk;
            tick();
            chk("ph1_ren", 32'(r_en), 0);
            chk("ph1_pclk", 32'(pclk), 0);
            prev = pclk;
        end
        tick();
        chk("tail_pclk", 32'(pclk), 1);
        if (pclk && !prev) rises++;
        if (pclk && rgb1 != 3'b000) nz++;
        chk("tail_rgb1", 32'(rgb1), 32'(ex(mem1[r * 64 + 63], p)));
        chk("tail_rgb2", 32'(rgb2), 32'(ex(mem2[r * 64 + 63], p)));
        last_tail_rgb = rgb1;
        last_nz       = nz;
        chk("pclk_rises", 32'(rises), 64);
        tick();
        chk("blank_pclk", 32'(pclk), 0);
        chk("blank_oe_n", 32'(oe_n), 1);
        chk("blank_row", 32'(row), r);
        chk("blank_lat", 32'(lat), 0);
        tick();
        chk("latch_lat", 32'(lat), 1);
        chk("latch_oe_n", 32'(oe_n), 1);
        chk("latch_row", 32'(row), r);
        for (int i = 0; i < (BASE_OE << p); i++) begin
            tick();
            chk("disp_oe_n", 32'(oe_n), 0);
            chk("disp_lat", 32'(lat), 0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        for (int a = 0; a < 2048; a++) begin
            mem1[a] = 16'(a);
            mem2[a] = 16'hF800;
        end

        // Reset state.
        tick();
        tick();
        chk("rst_addr", 32'(r_addr), 0);
        chk("rst_ren", 32'(r_en), 0);
        chk("rst_rgb1", 32'(rgb1), 0);
        chk("rst_rgb2", 32'(rgb2), 0);
        chk("rst_pclk", 32'(pclk), 0);
        chk("rst_lat", 32'(lat), 0);
        chk("rst_oe_n", 32'(oe_n), 1);
        chk("rst_row", 32'(row), 0);
        chk("rst_fdone", 32'(fdone), 0);

        rst_n = 1'b1;
        tick();
        chk("idle_ren", 32'(r_en), 0);
        chk("idle_oe_n", 32'(oe_n), 1);

        // Row 0, all five planes, addresses/data/timing checked cycle by cycle.
        cyc    = 0;
        enable = 1'b1;
        for (int p = 0; p < PLANES; p++) begin
            run_pass(0, p);
        end

        // Full frame: 32 rows x 903 cycles; the pulse lands one cycle after.
        while (fdone !== 1'b1 && cyc < 30000) tick();
        chk("frame_done_seen", 32'(fdone), 1);
        chk("frame_len", 32'(cyc), 28897);
        chk("frame_done_cnt", 32'(fd_cnt), 1);
        chk("frame_end_row", 32'(row), 31);
        chk("frame_wrap_addr", 32'(r_addr), 0);
        tick();
        chk("frame_done_pulse", 32'(fdone), 0);
        while (cyc < 28897 + 129) tick();
        chk("row_wrap", 32'(row), 0);

        // Drop enable during SHIFT of row 3 plane 2 (starts at cycle 31892).
        while (cyc < 31892 + 10) tick();
        chk("drop_addr", 32'(r_addr), 3 * 64 + 5);
        enable = 1'b0;
        while (cyc < 32022) tick();
        chk("drop_latch", 32'(lat), 1);
        chk("drop_row", 32'(row), 3);
        while (cyc < 32054) tick();
        chk("drop_disp_end", 32'(oe_n), 0);
        tick();
        chk("drop_idle_oe_n", 32'(oe_n), 1);
        chk("drop_idle_ren", 32'(r_en), 0);
        repeat (20) tick();
        chk("idle_hold_ren", 32'(r_en), 0);
        chk("idle_hold_oe_n", 32'(oe_n), 1);
        chk("idle_hold_pclk", 32'(pclk), 0);
        enable = 1'b1;
        run_pass(3, 3);

        // Asynchronous reset mid-SHIFT at column 17 of row 3 plane 4.
        repeat (35) tick();
        chk("pre_rst_addr", 32'(r_addr), 3 * 64 + 17);
        chk("pre_rst_ren", 32'(r_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(r_addr), 0);
        chk("mid_rst_ren", 32'(r_en), 0);
        chk("mid_rst_rgb1", 32'(rgb1), 0);
        chk("mid_rst_rgb2", 32'(rgb2), 0);
        chk("mid_rst_pclk", 32'(pclk), 0);
        chk("mid_rst_lat", 32'(lat), 0);
        chk("mid_rst_oe_n", 32'(oe_n), 1);
        chk("mid_rst_row", 32'(row), 0);
        tick();
        tick();

        // Single white pixel at the last column of row 0.
        for (int a = 0; a < 2048; a++) begin
            mem1[a] = 16'h0000;
            mem2[a] = 16'h0000;
        end
        mem1[63] = 16'hFFFF;
        rst_n = 1'b1;
        run_pass(0, 0);
        chk("pix_nonzero_edges", 32'(last_nz), 1);
        chk("pix_tail_rgb1", 32'(last_tail_rgb), 7);
        tick();
        chk("after_disp_oe_n", 32'(oe_n), 1);
        chk("next_plane_addr", 32'(r_addr), 0);
        chk("fd_total", 32'(fd_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
